apb_master_bridge: RTL and testbench

- APB requester that forwards an ALU result to one of four APB completers, and runs a 1-bit check read on request.
- Sits between the ALU/control datapath (i_* signals) and the APB bus (P* signals).
- Classic APB three-phase master FSM: IDLE, SETUP, ACCESS.
- Supports PREADY wait states and reports busy/done status back to the controller.

---
 rtl/apb_master_bridge.sv | 105 ++++++++++
 tb/tb_apb_master_bridge.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: forwards a valid ALU result as a write to one of four completers,
// or issues a 1-bit check read; classic IDLE/SETUP/ACCESS sequencing with wait states.
module apb_master_bridge #(
  parameter int m = 8
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         PREADY,
  input  logic         PRDATA,
  input  logic [m-1:0] i_data,
  input  logic         i_data_ready,
  input  logic         i_alu_error,
  input  logic [1:0]   i_protocol_sel,
  input  logic         i_data_check,
  output logic         PSEL0,
  output logic         PSEL1,
  output logic         PSEL2,
  output logic         PSEL3,
  output logic         PENABLE,
  output logic         PWRITE,
  output logic [m-1:0] PWDATA,
  output logic         o_waiting,
  output logic         o_transfer_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t     state_reg;
  logic [3:0] psel_reg;
  logic [3:0] sel_onehot;
  logic       write_req;

  // A flagged ALU result never becomes a write, but does not block a pending check read.
  assign write_req = i_data_ready & ~i_alu_error;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel_decode
      assign sel_onehot[gi] = (i_protocol_sel == 2'(gi));
    end
  endgenerate

  assign PSEL0 = psel_reg[0];
  assign PSEL1 = psel_reg[1];
  assign PSEL2 = psel_reg[2];
  assign PSEL3 = psel_reg[3];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg       <= IDLE;
      psel_reg        <= '0;
      PENABLE         <= 1'b0;
      PWRITE          <= 1'b0;
      PWDATA          <= '0;
      o_waiting       <= 1'b0;
      o_transfer_done <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          o_transfer_done <= 1'b0;
          if (write_req) begin
            state_reg <= SETUP;
            psel_reg  <= sel_onehot;
            PWDATA    <= i_data;
            PWRITE    <= 1'b1;
            o_waiting <= 1'b1;
          end else if (i_data_check) begin
            state_reg <= SETUP;
            psel_reg  <= sel_onehot;
            PWRITE    <= 1'b0;
            o_waiting <= 1'b1;
          end
        end
        SETUP: begin
          state_reg <= ACCESS;
          PENABLE   <= 1'b1;
        end
        ACCESS: begin
          // Select, direction and data stay frozen until the completer signals ready.
          if (PREADY) begin
            state_reg       <= IDLE;
            psel_reg        <= '0;
            PENABLE         <= 1'b0;
            PWRITE          <= 1'b0;
            o_waiting       <= 1'b0;
            o_transfer_done <= PWRITE | PRDATA;
          end
        end
        default: begin
          state_reg       <= IDLE;
          psel_reg        <= '0;
          PENABLE         <= 1'b0;
          PWRITE          <= 1'b0;
          o_waiting       <= 1'b0;
          o_transfer_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases plus randomized
// transactions, each checked phase by phase against a transaction-level model.
module tb_apb_master_bridge;
  localparam int M = 8;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic         PREADY;
  logic         PRDATA;
  logic [M-1:0] i_data;
  logic         i_data_ready;
  logic         i_alu_error;
  logic [1:0]   i_protocol_sel;
  logic         i_data_check;
  logic         PSEL0, PSEL1, PSEL2, PSEL3;
  logic         PENABLE, PWRITE;
  logic [M-1:0] PWDATA;
  logic         o_waiting, o_transfer_done;

  apb_master_bridge #(.m(M)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PREADY(PREADY), .PRDATA(PRDATA),
    .i_data(i_data), .i_data_ready(i_data_ready), .i_alu_error(i_alu_error),
    .i_protocol_sel(i_protocol_sel), .i_data_check(i_data_check),
    .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .o_waiting(o_waiting), .o_transfer_done(o_transfer_done)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [M-1:0] exp_pwdata;
  logic [3:0] psel;
  assign psel = {PSEL3, PSEL2, PSEL1, PSEL0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic done_exp);
    chk({tag, "_psel"}, 32'(psel), 32'h0);
    chk({tag, "_penable"}, 32'(PENABLE), 32'h0);
    chk({tag, "_pwrite"}, 32'(PWRITE), 32'h0);
    chk({tag, "_waiting"}, 32'(o_waiting), 32'h0);
    chk({tag, "_done"}, 32'(o_transfer_done), 32'(done_exp));
    chk({tag, "_pwdata"}, 32'(PWDATA), 32'(exp_pwdata));
  endtask

  task automatic idle_gap(input int n);
    i_data_ready = 1'b0;
    i_data_check = 1'b0;
    for (int k = 0; k < n; k++) begin
      i_alu_error    = 1'($urandom);
      i_protocol_sel = 2'($urandom);
      tick();
      check_idle("gap", 1'b0);
    end
  endtask

  // Called in an IDLE cycle; request is sampled at the next edge. Returns in the
  // cycle after completion (the done-pulse cycle) so calls can run back to back.
  task automatic do_txn(input logic rdy, input logic err, input logic chkreq,
                        input logic [1:0] sel, input logic [M-1:0] data,
                        input int waits, input logic rd_bit);
    logic is_wr, is_rd;
    logic [3:0] exp_sel;
    is_wr = rdy && !err;
    is_rd = !is_wr && chkreq;
    exp_sel = 4'b0001 << sel;
    i_data_ready = rdy; i_alu_error = err; i_data_check = chkreq;
    i_protocol_sel = sel; i_data = data;
    PREADY = 1'($urandom); PRDATA = 1'($urandom);
    tick();
    i_data_ready = 1'b0; i_data_check = 1'b0;
    i_alu_error = 1'($urandom); i_protocol_sel = 2'($urandom); i_data = M'($urandom);
    if (!is_wr && !is_rd) begin
      check_idle("noreq", 1'b0);
      $display("txn none  rdy=%0d err=%0d chk=%0d", rdy, err, chkreq);
      return;
    end
    if (is_wr) exp_pwdata = data;
    chk("setup_psel", 32'(psel), 32'(exp_sel));
    chk("setup_penable", 32'(PENABLE), 32'h0);
    chk("setup_pwrite", 32'(PWRITE), 32'(is_wr));
    chk("setup_pwdata", 32'(PWDATA), 32'(exp_pwdata));
    chk("setup_waiting", 32'(o_waiting), 32'h1);
    chk("setup_done", 32'(o_transfer_done), 32'h0);
    PREADY = 1'($urandom);
    for (int w = 0; w <= waits; w++) begin
      tick();
      chk("access_psel", 32'(psel), 32'(exp_sel));
      chk("access_penable", 32'(PENABLE), 32'h1);
      chk("access_pwrite", 32'(PWRITE), 32'(is_wr));
      chk("access_pwdata", 32'(PWDATA), 32'(exp_pwdata));
      chk("access_waiting", 32'(o_waiting), 32'h1);
      chk("access_done", 32'(o_transfer_done), 32'h0);
      i_protocol_sel = 2'($urandom);
      PREADY = (w == waits);
      PRDATA = (w == waits) ? rd_bit : 1'($urandom);
    end
    tick();
    PREADY = 1'($urandom);
    check_idle("complete", is_wr || rd_bit);
    $display("txn %s sel=%0d data=%02h waits=%0d prdata=%0d", is_wr ? "write" : "read ",
             sel, data, waits, rd_bit);
  endtask

  // Bus invariants checked every cycle outside reset.
  always @(negedge PCLK) begin
    if (PRESET === 1'b0) begin
      chk("psel_onehot", 32'($countones(psel) <= 1), 32'h1);
      chk("penable_wo_psel", 32'(PENABLE && (psel == 4'h0)), 32'h0);
    end
  end

  initial begin
    PRESET = 1'b1; PREADY = 1'b0; PRDATA = 1'b0; i_data = '0;
    i_data_ready = 1'b0; i_alu_error = 1'b0; i_protocol_sel = '0; i_data_check = 1'b0;
    exp_pwdata = '0;
    #12;
    check_idle("reset", 1'b0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    idle_gap(1);

    do_txn(1'b1, 1'b0, 1'b0, 2'd0, 8'hF3, 0, 1'b0);
    idle_gap(1);
    do_txn(1'b1, 1'b0, 1'b0, 2'd0, 8'hF3, 3, 1'b0);
    idle_gap(1);
    do_txn(1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 1, 1'b1);
    do_txn(1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 0, 1'b0);
    do_txn(1'b1, 1'b1, 1'b0, 2'd1, 8'h5A, 0, 1'b0);
    idle_gap(2);
    do_txn(1'b1, 1'b0, 1'b1, 2'd3, 8'hA7, 0, 1'b1);
    do_txn(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 2, 1'b1);
    do_txn(1'b1, 1'b1, 1'b1, 2'd1, 8'h3C, 0, 1'b1);

    // Asynchronous reset in the middle of a stalled ACCESS phase.
    i_data_ready = 1'b1; i_alu_error = 1'b0; i_protocol_sel = 2'd1; i_data = 8'h96;
    tick();
    i_data_ready = 1'b0; PREADY = 1'b0;
    tick();
    chk("pre_reset_penable", 32'(PENABLE), 32'h1);
    #2 PRESET = 1'b1;
    #1;
    exp_pwdata = '0;
    check_idle("async_reset", 1'b0);
    $display("txn reset mid-access");
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    PREADY = 1'b1;
    idle_gap(2);

    for (int t = 0; t < 60; t++) begin
      do_txn(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
             M'($urandom), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
